comparator_searcher: RTL

Sequential binary-search initiator that drives the B operand of a `comparator` instance and consumes its relational flags to discover an unknown A operand. Each cycle the searcher presents a guess on `valB`, samples `aGTb`/`aLTb`/`aEQb`, and narrows the interval until equality is reported. It is the active end of the comparator interface, used in lab builds to demonstrate closed-loop search with the structural comparator as the oracle.

---
 rtl/comparator_searcher.sv | 120 ++++++++++++
 1 files changed

// File: rtl/comparator_searcher.sv
// Closed-loop binary-search initiator: drives a guess on valB and narrows [lo, hi]
// from the attached comparator's flags until equality or an inconsistent oracle.
module comparator_searcher #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             aGTb,
    input  logic             aLTb,
    input  logic             aEQb,
    output logic [WIDTH-1:0] valB,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       probes
);

    localparam int unsigned BW = WIDTH + 1;
    localparam logic [BW-1:0] HiInit = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] ValMax = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ValInit = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {StIdle, StProbe, StDone} state_e;

    state_e        state;
    logic [BW-1:0] lo, hi;
    logic [BW-1:0] lo_gt, hi_lt, mid_gt, mid_lt;
    logic          one_hot, probe_end, probe_err;
    logic          unused_mid_msb;

    always_comb begin
        one_hot = ({aGTb, aLTb, aEQb} == 3'b100) || ({aGTb, aLTb, aEQb} == 3'b010) ||
                  ({aGTb, aLTb, aEQb} == 3'b001);
        lo_gt   = {1'b0, valB} + BW'(1);
        hi_lt   = {1'b0, valB} - BW'(1);
        // lo + hi never exceeds 2^(WIDTH+1)-1, so the sum cannot overflow BW bits
        mid_gt  = (lo_gt + hi) >> 1;
        mid_lt  = (lo + hi_lt) >> 1;

        probe_end = 1'b0;
        probe_err = 1'b0;
        if (!one_hot) begin
            probe_end = 1'b1;
            probe_err = 1'b1;
        end else if (aEQb) begin
            probe_end = 1'b1;
        end else if (aGTb) begin
            if (valB == ValMax || lo_gt > hi) begin
                probe_end = 1'b1;
                probe_err = 1'b1;
            end
        end else begin
            if (valB == '0 || lo > hi_lt) begin
                probe_end = 1'b1;
                probe_err = 1'b1;
            end
        end
    end

    // mid is at most 2^WIDTH-1 after the shift; its top bit is always zero
    assign unused_mid_msb = mid_gt[BW-1] ^ mid_lt[BW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            lo     <= '0;
            hi     <= '0;
            valB   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            result <= '0;
            probes <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state  <= StProbe;
                        lo     <= '0;
                        hi     <= HiInit;
                        valB   <= ValInit;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        error  <= 1'b0;
                        result <= '0;
                        probes <= '0;
                    end
                end
                StProbe: begin
                    probes <= probes + 4'd1;
                    if (one_hot && aEQb) begin
                        result <= valB;
                    end
                    if (one_hot && aGTb && valB != ValMax) begin
                        lo   <= lo_gt;
                        valB <= mid_gt[WIDTH-1:0];
                    end
                    if (one_hot && aLTb && valB != '0) begin
                        hi   <= hi_lt;
                        valB <= mid_lt[WIDTH-1:0];
                    end
                    if (probe_end) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= probe_err;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
